// File: rtl/tc_timer_irq_if.sv
// Bus interface of the timer: word-addressed register access from the MEM-stage
// bridge plus the interrupt request line that feeds one CP0 HWInt bit.
interface tc_timer_irq_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    // Bridge / CPU side drives the access and observes read data and the interrupt.
    modport master (
        output addr,
        output we,
        output wdata,
        input  rdata,
        input  irq
    );

    // Timer side answers reads and raises the interrupt.
    modport slave (
        input  addr,
        input  we,
        input  wdata,
        output rdata,
        output irq
    );
endinterface

// File: rtl/tc_timer_irq.sv
// Memory-mapped down-counting timer used as a CP0 interrupt source.
// Register map (word addresses): 0 = CTRL {IM, MODE[1:0], EN}, 1 = PRESET,
// 2 = COUNT (read-only), 3 = reserved (reads 0, writes dropped).
// Mode 0 (and 2'b1x) is one-shot: the interrupt flag is held and EN self-clears.
// Mode 1 is auto-reload: the flag pulses for one cycle and counting restarts.
module tc_timer_irq #(
    parameter int CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    tc_timer_irq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PRESET = 2'd1;
    localparam logic [1:0] ADDR_COUNT  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    state_t             state_q, state_d;
    logic [3:0]         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   preset_q, preset_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               irq_flag_q, irq_flag_d;

    logic               ctrl_en;
    logic               ctrl_im;
    logic               mode_reload;
    logic               ctrl_wr;
    logic               preset_wr;
    logic [CNT_W-1:0]   load_value;

    // CTRL field decode; only MODE == 2'b01 selects auto-reload, everything else is one-shot.
    assign ctrl_en     = ctrl_q[0];
    assign ctrl_im     = ctrl_q[3];
    assign mode_reload = (ctrl_q[2:1] == 2'b01);

    assign ctrl_wr   = bus.we && (bus.addr == ADDR_CTRL);
    assign preset_wr = bus.we && (bus.addr == ADDR_PRESET);

    // A zero PRESET would otherwise never reach the terminal count, so it loads as 1.
    assign load_value = (preset_q == CNT_ZERO) ? CNT_ONE : preset_q;

    // Next-state logic: FSM update first, then software writes override it.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            S_IDLE: begin
                if (ctrl_en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = load_value;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!ctrl_en) begin
                    state_d = S_IDLE;
                end else if (count_q > CNT_ONE) begin
                    count_d = count_q - CNT_ONE;
                end else begin
                    count_d    = CNT_ZERO;
                    irq_flag_d = 1'b1;
                    state_d    = S_INT;
                end
            end
            S_INT: begin
                state_d = S_IDLE;
                if (mode_reload) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (ctrl_wr) begin
            ctrl_d     = bus.wdata[3:0];
            irq_flag_d = 1'b0;
        end

        if (preset_wr) begin
            preset_d = bus.wdata[CNT_W-1:0];
        end
    end

    // State and register flops with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= CNT_ZERO;
            count_q    <= CNT_ZERO;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Combinational read mux; counter registers are zero-extended to the bus width.
    always_comb begin
        bus.rdata = 32'd0;
        case (bus.addr)
            ADDR_CTRL:   bus.rdata = {28'd0, ctrl_q};
            ADDR_PRESET: bus.rdata = 32'(preset_q);
            ADDR_COUNT:  bus.rdata = 32'(count_q);
            default:     bus.rdata = 32'd0;
        endcase
    end

    assign bus.irq = irq_flag_q & ctrl_im;

endmodule

// File: tb/tb_tc_timer_irq.sv
// Testbench for tc_timer_irq: a vector table for reset and the one-shot flow,
// hand-written sequences for the multi-cycle corner cases, and a randomized run
// compared against a timeline model that tracks the age of each counting run.
module tb_tc_timer_irq;

    logic clk;
    logic reset;

    int tests_run;
    int tests_failed;

    tc_timer_irq_if bus ();

    tc_timer_irq #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. A run starts on the edge where the timer is idle with EN
    // set; at age 1 the reload happens, at age a in 2..L+1 COUNT reads L-(a-2),
    // at age L+2 the flag rises, and the run ends on the following edge.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    bit          m_run;
    longint      m_age;
    longint      m_len;

    function automatic void modelStep(bit rst, bit we, logic [1:0] addr, logic [31:0] wdata);
        bit         en      = m_ctrl[0];
        bit         reload  = (m_ctrl[2:1] == 2'b01);
        logic [3:0] n_ctrl  = m_ctrl;
        logic       n_flag  = m_flag;
        if (rst) begin
            m_ctrl   = 4'd0;
            m_preset = 32'd0;
            m_count  = 32'd0;
            m_flag   = 1'b0;
            m_run    = 1'b0;
            m_age    = 0;
            m_len    = 0;
            return;
        end
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_age = 1;
            end
        end else if (m_age == 1) begin
            m_len   = (m_preset == 32'd0) ? 1 : longint'(m_preset);
            m_count = 32'(m_len);
            m_age   = 2;
        end else if (m_age <= m_len + 1) begin
            if (!en) begin
                m_run = 1'b0;
            end else if (m_age < m_len + 1) begin
                m_age   = m_age + 1;
                m_count = 32'(m_len - (m_age - 2));
            end else begin
                m_age   = m_age + 1;
                m_count = 32'd0;
                n_flag  = 1'b1;
            end
        end else begin
            m_run = 1'b0;
            if (reload) n_flag = 1'b0;
            else        n_ctrl[0] = 1'b0;
        end
        if (we && addr == 2'd0) begin
            n_ctrl = wdata[3:0];
            n_flag = 1'b0;
        end
        if (we && addr == 2'd1) begin
            m_preset = wdata;
        end
        m_ctrl = n_ctrl;
        m_flag = n_flag;
    endfunction

    function automatic logic [31:0] modelRead(logic [1:0] addr);
        case (addr)
            2'd0:    return {28'd0, m_ctrl};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    // Drive one edge's worth of inputs at the falling edge, step the model at the
    // rising edge and return 1 time unit later so outputs can be sampled.
    task automatic applyStimulus(input bit rst, input bit we, input logic [1:0] addr,
                                 input logic [31:0] wdata);
        @(negedge clk);
        reset     = rst;
        bus.we    = we;
        bus.addr  = addr;
        bus.wdata = wdata;
        @(posedge clk);
        modelStep(rst, we, addr, wdata);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        applyStimulus(1'b0, 1'b1, addr, data);
    endtask

    task automatic rd(input logic [1:0] addr);
        applyStimulus(1'b0, 1'b0, addr, 32'd0);
    endtask

    typedef struct {
        bit          rst;
        bit          we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_irq;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(bit rst, bit we, logic [1:0] addr, logic [31:0] wdata,
                                   logic [31:0] exp_rdata, bit exp_irq);
        vec_t v;
        v.rst       = rst;
        v.we        = we;
        v.addr      = addr;
        v.wdata     = wdata;
        v.exp_rdata = exp_rdata;
        v.exp_irq   = exp_irq;
        vecs.push_back(v);
    endfunction

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        bus.we       = 1'b0;
        bus.addr     = 2'd0;
        bus.wdata    = 32'd0;

        // Reset, all addresses read 0, dropped writes, then a mode-0 one-shot with PRESET=5.
        addVec(1, 0, 2'd0, 32'd0,          32'd0, 0);
        addVec(0, 0, 2'd1, 32'd0,          32'd0, 0);
        addVec(0, 0, 2'd2, 32'd0,          32'd0, 0);
        addVec(0, 0, 2'd3, 32'd0,          32'd0, 0);
        addVec(0, 1, 2'd3, 32'hFFFF_FFFF,  32'd0, 0);
        addVec(0, 1, 2'd2, 32'h0000_0055,  32'd0, 0);
        addVec(0, 1, 2'd1, 32'd5,          32'd5, 0);
        addVec(0, 1, 2'd0, 32'h9,          32'h9, 0);
        addVec(0, 0, 2'd2, 32'd0,          32'd0, 0);
        addVec(0, 0, 2'd2, 32'd0,          32'd5, 0);
        addVec(0, 0, 2'd2, 32'd0,          32'd4, 0);
        addVec(0, 0, 2'd2, 32'd0,          32'd3, 0);
        addVec(0, 0, 2'd2, 32'd0,          32'd2, 0);
        addVec(0, 0, 2'd2, 32'd0,          32'd1, 0);
        addVec(0, 0, 2'd2, 32'd0,          32'd0, 1);
        addVec(0, 0, 2'd0, 32'd0,          32'h8, 1);
        addVec(0, 0, 2'd0, 32'd0,          32'h8, 1);
        addVec(0, 1, 2'd0, 32'd0,          32'd0, 0);
        addVec(0, 0, 2'd2, 32'd0,          32'd0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d irq", i), {31'd0, bus.irq}, {31'd0, vecs[i].exp_irq});
        end

        // Auto-reload, PRESET=3: one-cycle pulses at t+5, t+11, t+17.
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            rd(2'd0);
            checkOutput($sformatf("reload irq t+%0d", k), {31'd0, bus.irq},
                        (k == 5 || k == 11 || k == 17) ? 32'd1 : 32'd0);
        end
        checkOutput("reload EN kept", bus.rdata, 32'hB);
        wr(2'd0, 32'd0);

        // Disable mid-count freezes COUNT; re-enable reloads the new PRESET.
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) rd(2'd2);
        checkOutput("count before disable", bus.rdata, 32'd3);
        wr(2'd0, 32'h8);
        for (int k = 0; k < 3; k++) begin
            rd(2'd2);
            checkOutput($sformatf("frozen count %0d", k), bus.rdata, 32'd2);
            checkOutput($sformatf("frozen irq %0d", k), {31'd0, bus.irq}, 32'd0);
        end
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        rd(2'd2);
        checkOutput("reenable load cycle", bus.rdata, 32'd2);
        rd(2'd2);
        checkOutput("reenable reload", bus.rdata, 32'd4);
        wr(2'd1, 32'd7);
        checkOutput("preset write in CNT", bus.rdata, 32'd7);
        rd(2'd2);
        checkOutput("count ignores new preset", bus.rdata, 32'd2);
        wr(2'd0, 32'd0);
        rd(2'd2);
        checkOutput("count after stop", bus.rdata, 32'd1);

        // CTRL write on the CNT->INT edge wins: flag ends 0, then EN self-clears.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h9);
        rd(2'd0);
        rd(2'd0);
        rd(2'd0);
        checkOutput("prio pre irq", {31'd0, bus.irq}, 32'd0);
        wr(2'd0, 32'h9);
        checkOutput("prio ctrl", bus.rdata, 32'h9);
        checkOutput("prio irq", {31'd0, bus.irq}, 32'd0);
        rd(2'd0);
        checkOutput("prio EN cleared", bus.rdata, 32'h8);
        checkOutput("prio irq after", {31'd0, bus.irq}, 32'd0);

        // PRESET=0 counts as 1: interrupt three edges after enable.
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        rd(2'd2);
        rd(2'd2);
        checkOutput("preset0 count", bus.rdata, 32'd1);
        checkOutput("preset0 early irq", {31'd0, bus.irq}, 32'd0);
        rd(2'd2);
        checkOutput("preset0 irq", {31'd0, bus.irq}, 32'd1);
        wr(2'd0, 32'd0);
        checkOutput("preset0 ack", {31'd0, bus.irq}, 32'd0);

        // IM=0 hides the flag; writing CTRL=IM only acknowledges it.
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            rd(2'd0);
            checkOutput($sformatf("masked irq %0d", k), {31'd0, bus.irq}, 32'd0);
        end
        checkOutput("masked EN cleared", bus.rdata, 32'd0);
        wr(2'd0, 32'h8);
        rd(2'd0);
        checkOutput("masked ack irq", {31'd0, bus.irq}, 32'd0);

        // Reset in the middle of a count clears everything on that edge.
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) rd(2'd2);
        checkOutput("count before reset", bus.rdata, 32'd7);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'd0);
        checkOutput("reset count", bus.rdata, 32'd0);
        checkOutput("reset irq", {31'd0, bus.irq}, 32'd0);
        rd(2'd0);
        checkOutput("reset ctrl", bus.rdata, 32'd0);
        rd(2'd1);
        checkOutput("reset preset", bus.rdata, 32'd0);
        rd(2'd2);
        rd(2'd2);
        checkOutput("reset stays idle", bus.rdata, 32'd0);

        // Randomized traffic compared cycle by cycle with the model.
        applyStimulus(1'b1, 1'b0, 2'd0, 32'd0);
        for (int n = 0; n < 1500; n++) begin
            int          r;
            bit          rst;
            bit          we;
            logic [1:0]  addr;
            logic [31:0] wdata;
            r     = int'($urandom_range(0, 199));
            rst   = (r == 0);
            we    = (r > 0 && r < 18);
            addr  = 2'($urandom_range(0, 3));
            wdata = (addr == 2'd1) ? 32'($urandom_range(0, 6)) : 32'($urandom);
            applyStimulus(rst, we, addr, wdata);
            checkOutput($sformatf("rand%0d rdata", n), bus.rdata, modelRead(addr));
            checkOutput($sformatf("rand%0d irq", n), {31'd0, bus.irq},
                        {31'd0, m_flag & m_ctrl[3]});
        end

        @(negedge clk);
        bus.we = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
